// File: rtl/ptw_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------------------+
// | ptw_mem_responder: round-robin PTE read responder between ITLB/DTLB and AXI4 reads    |
// | Revision: 1.0                                                                         |
// +--------------------------------------------------------------------------------------+
module ptw_mem_responder #(
  parameter int DATA_WIDTH     = 64,
  parameter int ADDR_WIDTH     = 64,
  parameter int AXI_ADDR_WIDTH = 56,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      ITLB_ADDR_VALID,
  input  logic [ADDR_WIDTH-1:0]     ITLB_ADDR,
  output logic                      ITLB_DATA_VALID,
  output logic [DATA_WIDTH-1:0]     ITLB_DATA,
  output logic                      ITLB_ERR,
  input  logic                      DTLB_ADDR_VALID,
  input  logic [ADDR_WIDTH-1:0]     DTLB_ADDR,
  output logic                      DTLB_DATA_VALID,
  output logic [DATA_WIDTH-1:0]     DTLB_DATA,
  output logic                      DTLB_ERR,
  output logic                      M_ARVALID,
  input  logic                      M_ARREADY,
  output logic [AXI_ADDR_WIDTH-1:0] M_ARADDR,
  output logic [7:0]                M_ARLEN,
  output logic [2:0]                M_ARSIZE,
  output logic [1:0]                M_ARBURST,
  output logic [2:0]                M_ARPROT,
  input  logic                      M_RVALID,
  output logic                      M_RREADY,
  input  logic [DATA_WIDTH-1:0]     M_RDATA,
  input  logic [1:0]                M_RRESP,
  input  logic                      M_RLAST
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TIMEOUT_LIMIT = TW'(TIMEOUT_CYCLES);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_AR    = 2'd1;
  localparam logic [1:0] S_R     = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]                  state;
  logic                        pend_i;
  logic                        pend_d;
  logic [AXI_ADDR_WIDTH-4:0]   addr_i;
  logic [AXI_ADDR_WIDTH-4:0]   addr_d;
  logic                        owner;   // 0 = ITLB, 1 = DTLB
  logic                        prefer;  // requester favoured when both are pending
  logic [TW-1:0]               timer;
  logic [TW-1:0]               timer_inc;
  logic                        grant_d;
  logic                        timed_out;
  logic                        done;
  logic                        done_ok;
  logic                        unused_addr_bits;

  assign M_ARLEN   = 8'd0;
  assign M_ARSIZE  = 3'd3;
  assign M_ARBURST = 2'b01;
  assign M_ARPROT  = 3'b001;

  // Only the 8-byte-aligned physical bits are ever forwarded.
  assign unused_addr_bits = ^{ITLB_ADDR[ADDR_WIDTH-1:AXI_ADDR_WIDTH], ITLB_ADDR[2:0],
                              DTLB_ADDR[ADDR_WIDTH-1:AXI_ADDR_WIDTH], DTLB_ADDR[2:0]};

  always_comb begin
    timer_inc = timer + TW'(1);
    grant_d   = pend_d && (!pend_i || prefer);
    timed_out = (TIMEOUT_CYCLES != 0) && (state == S_R) && !M_RVALID && (timer_inc == TIMEOUT_LIMIT);
    done      = (state == S_R) && (M_RVALID || timed_out);
    done_ok   = M_RVALID && (M_RRESP == 2'b00) && M_RLAST;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state           <= S_IDLE;
      pend_i          <= 1'b0;
      pend_d          <= 1'b0;
      addr_i          <= '0;
      addr_d          <= '0;
      owner           <= 1'b0;
      prefer          <= 1'b0;
      timer           <= '0;
      M_ARVALID       <= 1'b0;
      M_ARADDR        <= '0;
      M_RREADY        <= 1'b0;
      ITLB_DATA_VALID <= 1'b0;
      ITLB_DATA       <= '0;
      ITLB_ERR        <= 1'b0;
      DTLB_DATA_VALID <= 1'b0;
      DTLB_DATA       <= '0;
      DTLB_ERR        <= 1'b0;
    end else begin
      ITLB_DATA_VALID <= 1'b0;
      ITLB_ERR        <= 1'b0;
      DTLB_DATA_VALID <= 1'b0;
      DTLB_ERR        <= 1'b0;

      // A slot stays occupied from capture until its response, so pulses in between are dropped.
      if (ITLB_ADDR_VALID && !pend_i) begin
        pend_i <= 1'b1;
        addr_i <= ITLB_ADDR[AXI_ADDR_WIDTH-1:3];
      end
      if (DTLB_ADDR_VALID && !pend_d) begin
        pend_d <= 1'b1;
        addr_d <= DTLB_ADDR[AXI_ADDR_WIDTH-1:3];
      end

      if (done) begin
        prefer <= ~owner;
        if (owner) begin
          pend_d          <= 1'b0;
          DTLB_DATA       <= done_ok ? M_RDATA : '0;
          DTLB_DATA_VALID <= done_ok;
          DTLB_ERR        <= !done_ok;
        end else begin
          pend_i          <= 1'b0;
          ITLB_DATA       <= done_ok ? M_RDATA : '0;
          ITLB_DATA_VALID <= done_ok;
          ITLB_ERR        <= !done_ok;
        end
      end

      case (state)
        S_IDLE: begin
          if (pend_i || pend_d) begin
            owner     <= grant_d;
            M_ARADDR  <= {(grant_d ? addr_d : addr_i), 3'b000};
            M_ARVALID <= 1'b1;
            state     <= S_AR;
          end
        end
        S_AR: begin
          if (M_ARREADY) begin
            M_ARVALID <= 1'b0;
            M_RREADY  <= 1'b1;
            timer     <= '0;
            state     <= S_R;
          end
        end
        S_R: begin
          if (M_RVALID) begin
            M_RREADY <= 1'b0;
            state    <= S_IDLE;
          end else if (timed_out) begin
            // Keep RREADY high so the late beat is swallowed before any new AR.
            state <= S_DRAIN;
          end else begin
            timer <= timer_inc;
          end
        end
        S_DRAIN: begin
          if (M_RVALID) begin
            M_RREADY <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ptw_mem_responder.sv
`default_nettype none
// Directed bench for ptw_mem_responder with a hand-driven AXI read slave.
module tb_ptw_mem_responder;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ITLB_ADDR_VALID, DTLB_ADDR_VALID;
  logic [63:0] ITLB_ADDR, DTLB_ADDR;
  logic        ITLB_DATA_VALID, ITLB_ERR, DTLB_DATA_VALID, DTLB_ERR;
  logic [63:0] ITLB_DATA, DTLB_DATA;
  logic        M_ARVALID, M_ARREADY, M_RVALID, M_RREADY, M_RLAST;
  logic [55:0] M_ARADDR;
  logic [7:0]  M_ARLEN;
  logic [2:0]  M_ARSIZE, M_ARPROT;
  logic [1:0]  M_ARBURST, M_RRESP;
  logic [63:0] M_RDATA;

  int checks = 0;
  int errors = 0;
  int i_ok = 0, i_err = 0, d_ok = 0, d_err = 0, excl = 0;

  always #5 CLK = ~CLK;

  ptw_mem_responder #(
    .DATA_WIDTH(64), .ADDR_WIDTH(64), .AXI_ADDR_WIDTH(56), .TIMEOUT_CYCLES(8)
  ) dut (
    .CLK(CLK), .RST(RST),
    .ITLB_ADDR_VALID(ITLB_ADDR_VALID), .ITLB_ADDR(ITLB_ADDR),
    .ITLB_DATA_VALID(ITLB_DATA_VALID), .ITLB_DATA(ITLB_DATA), .ITLB_ERR(ITLB_ERR),
    .DTLB_ADDR_VALID(DTLB_ADDR_VALID), .DTLB_ADDR(DTLB_ADDR),
    .DTLB_DATA_VALID(DTLB_DATA_VALID), .DTLB_DATA(DTLB_DATA), .DTLB_ERR(DTLB_ERR),
    .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY), .M_ARADDR(M_ARADDR),
    .M_ARLEN(M_ARLEN), .M_ARSIZE(M_ARSIZE), .M_ARBURST(M_ARBURST), .M_ARPROT(M_ARPROT),
    .M_RVALID(M_RVALID), .M_RREADY(M_RREADY), .M_RDATA(M_RDATA),
    .M_RRESP(M_RRESP), .M_RLAST(M_RLAST)
  );

  always @(negedge CLK) begin
    if (ITLB_DATA_VALID) i_ok++;
    if (ITLB_ERR)        i_err++;
    if (DTLB_DATA_VALID) d_ok++;
    if (DTLB_ERR)        d_err++;
    if (int'(ITLB_DATA_VALID) + int'(ITLB_ERR) + int'(DTLB_DATA_VALID) + int'(DTLB_ERR) > 1) excl++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
  endtask

  task automatic pulse_itlb(input logic [63:0] a);
    ITLB_ADDR = a; ITLB_ADDR_VALID = 1'b1;
    tick();
    ITLB_ADDR_VALID = 1'b0;
  endtask

  task automatic pulse_dtlb(input logic [63:0] a);
    DTLB_ADDR = a; DTLB_ADDR_VALID = 1'b1;
    tick();
    DTLB_ADDR_VALID = 1'b0;
  endtask

  // Wait (bounded) for ARVALID, hold ARREADY low for ar_wait cycles, then handshake.
  task automatic ar_phase(input string tag, input logic [55:0] addr, input int ar_wait);
    int n = 0;
    while (M_ARVALID !== 1'b1 && n < 20) begin tick(); n++; end
    chk({tag, "_arvalid"}, 64'(M_ARVALID), 64'd1);
    chk({tag, "_araddr"}, 64'(M_ARADDR), 64'(addr));
    for (int k = 0; k < ar_wait; k++) begin
      tick();
      chk({tag, "_arvalid_hold"}, 64'(M_ARVALID), 64'd1);
      chk({tag, "_araddr_hold"}, 64'(M_ARADDR), 64'(addr));
    end
    M_ARREADY = 1'b1;
    tick();
    M_ARREADY = 1'b0;
    chk({tag, "_arvalid_drop"}, 64'(M_ARVALID), 64'd0);
    chk({tag, "_rready"}, 64'(M_RREADY), 64'd1);
  endtask

  task automatic r_beat(input int r_wait, input logic [63:0] data, input logic [1:0] resp);
    repeat (r_wait) tick();
    M_RDATA = data; M_RRESP = resp; M_RLAST = 1'b1; M_RVALID = 1'b1;
    tick();
    M_RVALID = 1'b0; M_RLAST = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    ITLB_ADDR_VALID = 1'b0; DTLB_ADDR_VALID = 1'b0;
    ITLB_ADDR = '0; DTLB_ADDR = '0;
    M_ARREADY = 1'b0; M_RVALID = 1'b0; M_RDATA = '0; M_RRESP = '0; M_RLAST = 1'b0;
    repeat (3) tick();
    chk("rst_arvalid", 64'(M_ARVALID), 64'd0);
    chk("rst_araddr", 64'(M_ARADDR), 64'd0);
    chk("rst_rready", 64'(M_RREADY), 64'd0);
    chk("rst_itlb_dv", 64'(ITLB_DATA_VALID), 64'd0);
    chk("rst_itlb_data", ITLB_DATA, 64'd0);
    chk("rst_dtlb_err", 64'(DTLB_ERR), 64'd0);
    chk("const_arlen", 64'(M_ARLEN), 64'd0);
    chk("const_arsize", 64'(M_ARSIZE), 64'd3);
    chk("const_arburst", 64'(M_ARBURST), 64'd1);
    chk("const_arprot", 64'(M_ARPROT), 64'd1);
    RST = 1'b0;
    tick();

    // Basic ITLB walk
    pulse_itlb(64'h8000_1008);
    ar_phase("t1", 56'h8000_1008, 0);
    r_beat(3, 64'hCF, 2'b00);
    chk("t1_itlb_dv", 64'(ITLB_DATA_VALID), 64'd1);
    chk("t1_itlb_data", ITLB_DATA, 64'hCF);
    chk("t1_itlb_err", 64'(ITLB_ERR), 64'd0);
    chk("t1_dtlb_dv", 64'(DTLB_DATA_VALID), 64'd0);
    chk("t1_dtlb_err", 64'(DTLB_ERR), 64'd0);
    tick();
    chk("t1_itlb_dv_drop", 64'(ITLB_DATA_VALID), 64'd0);
    chk("t1_itlb_data_hold", ITLB_DATA, 64'hCF);

    // Simultaneous requests after reset: ITLB first, then DTLB
    do_reset();
    ITLB_ADDR = 64'h1000; DTLB_ADDR = 64'h2000;
    ITLB_ADDR_VALID = 1'b1; DTLB_ADDR_VALID = 1'b1;
    tick();
    ITLB_ADDR_VALID = 1'b0; DTLB_ADDR_VALID = 1'b0;
    ar_phase("t2a", 56'h1000, 0);
    r_beat(1, 64'h11, 2'b00);
    chk("t2a_itlb_dv", 64'(ITLB_DATA_VALID), 64'd1);
    chk("t2a_itlb_data", ITLB_DATA, 64'h11);
    chk("t2a_dtlb_dv", 64'(DTLB_DATA_VALID), 64'd0);
    ar_phase("t2b", 56'h2000, 0);
    r_beat(1, 64'h22, 2'b00);
    chk("t2b_dtlb_dv", 64'(DTLB_DATA_VALID), 64'd1);
    chk("t2b_dtlb_data", DTLB_DATA, 64'h22);
    chk("t2b_itlb_data_hold", ITLB_DATA, 64'h11);

    // Unaligned address and AR back-pressure
    pulse_itlb(64'h8000_100F);
    ar_phase("t3", 56'h8000_1008, 5);
    r_beat(0, 64'h33, 2'b00);
    chk("t3_itlb_dv", 64'(ITLB_DATA_VALID), 64'd1);
    chk("t3_itlb_data", ITLB_DATA, 64'h33);

    // SLVERR to DTLB, then a clean DTLB walk
    pulse_dtlb(64'h4000);
    ar_phase("t4", 56'h4000, 0);
    r_beat(2, 64'hDEAD, 2'b10);
    chk("t4_dtlb_err", 64'(DTLB_ERR), 64'd1);
    chk("t4_dtlb_dv", 64'(DTLB_DATA_VALID), 64'd0);
    chk("t4_dtlb_data", DTLB_DATA, 64'd0);
    chk("t4_itlb_err", 64'(ITLB_ERR), 64'd0);
    tick();
    chk("t4_dtlb_err_drop", 64'(DTLB_ERR), 64'd0);
    pulse_dtlb(64'h4008);
    ar_phase("t4b", 56'h4008, 0);
    r_beat(1, 64'h44, 2'b00);
    chk("t4b_dtlb_dv", 64'(DTLB_DATA_VALID), 64'd1);
    chk("t4b_dtlb_data", DTLB_DATA, 64'h44);

    // Timeout after 8 R cycles, late beat drained silently
    pulse_itlb(64'h5000);
    ar_phase("t5", 56'h5000, 0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k < 8) chk("t5_err_early", 64'(ITLB_ERR), 64'd0);
      else       chk("t5_err_timeout", 64'(ITLB_ERR), 64'd1);
    end
    chk("t5_itlb_dv", 64'(ITLB_DATA_VALID), 64'd0);
    chk("t5_itlb_data", ITLB_DATA, 64'd0);
    chk("t5_rready_drain", 64'(M_RREADY), 64'd1);
    pulse_dtlb(64'h6000);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t5_no_ar_in_drain", 64'(M_ARVALID), 64'd0);
    end
    r_beat(0, 64'hBAD, 2'b00);
    chk("t5_late_itlb_dv", 64'(ITLB_DATA_VALID), 64'd0);
    chk("t5_late_itlb_err", 64'(ITLB_ERR), 64'd0);
    chk("t5_late_dtlb_dv", 64'(DTLB_DATA_VALID), 64'd0);
    chk("t5_late_rready", 64'(M_RREADY), 64'd0);
    ar_phase("t5b", 56'h6000, 0);
    r_beat(1, 64'h55, 2'b00);
    chk("t5b_dtlb_dv", 64'(DTLB_DATA_VALID), 64'd1);
    chk("t5b_dtlb_data", DTLB_DATA, 64'h55);

    // Reset while waiting in R
    pulse_itlb(64'h7000);
    ar_phase("t6", 56'h7000, 0);
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("t6_arvalid", 64'(M_ARVALID), 64'd0);
    chk("t6_araddr", 64'(M_ARADDR), 64'd0);
    chk("t6_rready", 64'(M_RREADY), 64'd0);
    chk("t6_itlb_data", ITLB_DATA, 64'd0);
    chk("t6_dtlb_data", DTLB_DATA, 64'd0);
    chk("t6_itlb_err", 64'(ITLB_ERR), 64'd0);
    pulse_dtlb(64'h8000);
    ar_phase("t6b", 56'h8000, 0);
    r_beat(1, 64'h66, 2'b00);
    chk("t6b_dtlb_dv", 64'(DTLB_DATA_VALID), 64'd1);
    chk("t6b_dtlb_data", DTLB_DATA, 64'h66);
    tick();
    tick();
    chk("t6_idle_after", 64'(M_ARVALID), 64'd0);

    // Pulse totals and exclusivity across the whole run
    chk("tot_itlb_ok", 64'(i_ok), 64'd3);
    chk("tot_itlb_err", 64'(i_err), 64'd1);
    chk("tot_dtlb_ok", 64'(d_ok), 64'd4);
    chk("tot_dtlb_err", 64'(d_err), 64'd1);
    chk("exclusive_pulses", 64'(excl), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
